backscatter_burst_ctrl: RTL

BACKSCATTER_BURST_CTRL -- requirements
Module: backscatter_burst_ctrl

---
 rtl/backscatter_burst_ctrl_if.sv | 29 ++
 rtl/backscatter_burst_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/backscatter_burst_ctrl_if.sv
// rtl/backscatter_burst_ctrl_if.sv - trigger/payload inputs and RF/status outputs of the burst controller
interface backscatter_burst_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  trigger_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rf_ctrl;
  logic                  busy;
  logic                  done;
  logic                  overrun;

  modport master (
    output trigger_in,
    output data_in,
    input  rf_ctrl,
    input  busy,
    input  done,
    input  overrun
  );

  modport slave (
    input  trigger_in,
    input  data_in,
    output rf_ctrl,
    output busy,
    output done,
    output overrun
  );
endinterface

// File: rtl/backscatter_burst_ctrl.sv
// rtl/backscatter_burst_ctrl.sv - triggered backscatter burst: delay, then phase-modulated carrier, MSB first
module backscatter_burst_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int START_DELAY = 32,
  parameter int BIT_CYCLES  = 20,
  parameter int HALF_PERIOD = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  backscatter_burst_ctrl_if.slave    bus
);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, SEND, DONE} state_t;

  state_t                state, state_n;
  logic                  trig_q;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [15:0]           delay_cnt, delay_cnt_n;
  logic [7:0]            bit_cnt, bit_cnt_n;
  logic [7:0]            half_cnt, half_cnt_n;
  logic [IDX_W-1:0]      bit_idx, bit_idx_n;
  logic                  carrier, carrier_n;
  logic                  rf_q, rf_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  overrun_q, overrun_n;
  logic                  rise;

  assign bus.rf_ctrl = rf_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

  // trig_q resets high so a trigger already asserted at reset release is not a rise
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      trig_q    <= 1'b1;
      shreg     <= '0;
      delay_cnt <= '0;
      bit_cnt   <= '0;
      half_cnt  <= '0;
      bit_idx   <= '0;
      carrier   <= 1'b0;
      rf_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      trig_q    <= bus.trigger_in;
      shreg     <= shreg_n;
      delay_cnt <= delay_cnt_n;
      bit_cnt   <= bit_cnt_n;
      half_cnt  <= half_cnt_n;
      bit_idx   <= bit_idx_n;
      carrier   <= carrier_n;
      rf_q      <= rf_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      overrun_q <= overrun_n;
    end
  end

  always_comb begin
    rise        = bus.trigger_in & ~trig_q;
    state_n     = state;
    shreg_n     = shreg;
    delay_cnt_n = delay_cnt;
    bit_cnt_n   = bit_cnt;
    half_cnt_n  = half_cnt;
    bit_idx_n   = bit_idx;
    carrier_n   = carrier;

    case (state)
      IDLE: begin
        if (rise) begin
          state_n     = DELAY;
          shreg_n     = bus.data_in;
          delay_cnt_n = '0;
        end
      end
      DELAY: begin
        if (delay_cnt == 16'(START_DELAY - 1)) begin
          state_n    = SEND;
          bit_cnt_n  = '0;
          half_cnt_n = '0;
          bit_idx_n  = '0;
          carrier_n  = 1'b0;
        end else begin
          delay_cnt_n = delay_cnt + 16'd1;
        end
      end
      SEND: begin
        // carrier phase is independent of bit boundaries
        if (half_cnt == 8'(HALF_PERIOD - 1)) begin
          half_cnt_n = '0;
          carrier_n  = ~carrier;
        end else begin
          half_cnt_n = half_cnt + 8'd1;
        end
        if (bit_cnt == 8'(BIT_CYCLES - 1)) begin
          bit_cnt_n = '0;
          shreg_n   = {shreg[DATA_WIDTH-2:0], 1'b0};
          if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
            state_n = DONE;
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end else begin
          bit_cnt_n = bit_cnt + 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // outputs are registered, so they are derived from the state being entered
    overrun_n = overrun_q | (rise & (state != IDLE));
    busy_n    = (state_n == DELAY) || (state_n == SEND);
    done_n    = (state_n == DONE);
    rf_n      = (state_n == SEND) & (carrier_n ^ shreg_n[DATA_WIDTH-1]);
  end
endmodule
